// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller.
// Accepts two WIDTH-bit operands plus a carry-in over a valid/ready handshake,
// runs them LSB-first through a single 1-bit full adder (one bit per clock,
// carry registered between bits) and returns sum/cout over a second
// valid/ready handshake.
// Optional feature: define SERIAL_SUB_EN to add a 'sub' input that turns the
// operation into a - b (mod 2^WIDTH), with cout=1 meaning "no borrow".

// Shared 1-bit full adder cell.
module full_adder (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (ci & (x ^ y));
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic [WIDTH-1:0] res_next;
    logic             carry_q;
    logic [CW-1:0]    cnt;

    logic             fa_s;
    logic             fa_co;
    logic             last_bit;
    logic             accept;
    logic [WIDTH-1:0] load_b;
    logic             load_c;

    assign accept   = in_valid && in_ready;
    assign last_bit = (cnt == CW'(WIDTH - 1));

    // Operand B and the initial carry as loaded at accept time.
`ifdef SERIAL_SUB_EN
    // Subtraction is a + ~b + 1, so the caller's cin is irrelevant then.
    assign load_b = sub ? ~b   : b;
    assign load_c = sub ? 1'b1 : cin;
`else
    assign load_b = b;
    assign load_c = cin;
`endif

    full_adder u_fa (
        .x  (a_sh[0]),
        .y  (b_sh[0]),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    // Result register after this bit's sum enters at the MSB; a 1-bit
    // result has nothing to shift down, so it is just the new sum bit.
    generate
        if (WIDTH == 1) begin : g_res_w1
            assign res_next = fa_s;
        end else begin : g_res_wn
            assign res_next = {fa_s, res_sh[WIDTH-1:1]};
        end
    endgenerate

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking (<=) so every register
        // samples pre-edge values regardless of statement order.
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic plus the state-decoded handshake/status outputs.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        state_d  = state_q;
        in_ready = 1'b0;
        busy     = 1'b1;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) state_d = RUN;
            end
            RUN: begin
                if (last_bit) state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Serial datapath: load on accept, shift one bit per RUN cycle, capture
    // the result on the last bit, drop out_valid on the output handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the shift registers are flops, not a memory array, so
            // clearing them on reset is cheap and keeps them deterministic.
            a_sh      <= '0;
            b_sh      <= '0;
            res_sh    <= '0;
            carry_q   <= 1'b0;
            cnt       <= '0;
            sum       <= '0;
            cout      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        a_sh    <= a;
                        b_sh    <= load_b;
                        carry_q <= load_c;
                        res_sh  <= '0;
                        cnt     <= '0;
                    end
                end
                RUN: begin
                    a_sh    <= a_sh >> 1;
                    b_sh    <= b_sh >> 1;
                    res_sh  <= res_next;
                    carry_q <= fa_co;
                    cnt     <= cnt + 1'b1;
                    if (last_bit) begin
                        sum       <= res_next;
                        cout      <= fa_co;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: begin
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8).
// Expected results are pushed to a scoreboard queue at each accepted input
// handshake and popped/compared at each output handshake.
module tb_serial_adder_ctrl;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [WIDTH:0] exp_q[$];
    int             accept_cyc[$];

    serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef SERIAL_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Reference model: {cout, sum} of the requested operation.
    function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                                             input logic mc, input logic ms);
        logic [WIDTH:0] r;
        if (ms) r = {1'b0, ma} + {1'b0, ~mb} + (WIDTH+1)'(1);
        else    r = {1'b0, ma} + {1'b0, mb} + {{WIDTH{1'b0}}, mc};
        return r;
    endfunction

    // Scoreboard push: an input handshake happens at the next rising edge.
    always @(negedge clk) begin
        if (rst_n && in_valid && in_ready) begin
`ifdef SERIAL_SUB_EN
            exp_q.push_back(model(a, b, cin, sub));
`else
            exp_q.push_back(model(a, b, cin, 1'b0));
`endif
            accept_cyc.push_back(cyc);
        end
    end

    // Scoreboard pop: an output handshake happens at the next rising edge.
    always @(negedge clk) begin
        logic [WIDTH:0] e;
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("sb_sum", 32'(sum), 32'(e[WIDTH-1:0]));
                check("sb_cout", 32'(cout), 32'(e[WIDTH]));
            end
        end
    end

    // Present operands and hold in_valid until one accept edge has passed.
    task automatic send(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_, input logic tc);
        int n = 0;
        @(posedge clk); #1;
        a = ta; b = tb_; cin = tc; in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Count rising edges from the accept edge until out_valid is seen.
    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        if (lat >= 100) check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("sb_drain", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int lat;
        int quiet;

        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b0;
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        @(negedge clk); rst_n = 1'b1;

        // 1: basic add and latency (out_valid after WIDTH edges past accept).
        out_ready = 1'b1;
        send(8'h5A, 8'h33, 1'b0);
        check("t1_busy", 32'(busy), 32'd1);
        wait_done(lat);
        check("t1_latency", 32'(lat), 32'(WIDTH));
        check("t1_sum", 32'(sum), 32'h8D);
        check("t1_cout", 32'(cout), 32'd0);
        drain();

        // 2: carry out of the top bit, and all-ones with carry-in.
        send(8'hFF, 8'h01, 1'b0);
        wait_done(lat);
        check("t2a_sum", 32'(sum), 32'h00);
        check("t2a_cout", 32'(cout), 32'd1);
        send(8'hFF, 8'hFF, 1'b1);
        wait_done(lat);
        check("t2b_sum", 32'(sum), 32'hFF);
        check("t2b_cout", 32'(cout), 32'd1);
        drain();

        // 3: back-pressure in DONE with noisy inputs; result must hold.
        out_ready = 1'b0;
        send(8'h12, 8'h34, 1'b1);
        wait_done(lat);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            in_valid = ~in_valid;
            a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
            @(negedge clk);
            check("t3_out_valid", 32'(out_valid), 32'd1);
            check("t3_sum", 32'(sum), 32'h47);
            check("t3_cout", 32'(cout), 32'd0);
            check("t3_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("t3_no_second_accept", 32'(exp_q.size()), 32'd1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("t3_in_ready_after", 32'(in_ready), 32'd1);
        check("t3_out_valid_after", 32'(out_valid), 32'd0);
        check("t3_sum_held", 32'(sum), 32'h47);

        // 5: reset in the 3rd RUN cycle aborts the transaction.
        send(8'h55, 8'h0A, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("t5_in_ready", 32'(in_ready), 32'd1);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_out_valid", 32'(out_valid), 32'd0);
        check("t5_sum", 32'(sum), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        quiet = 1;
        for (int i = 0; i < WIDTH + 4; i++) begin
            @(negedge clk);
            if (out_valid) quiet = 0;
        end
        check("t5_no_pulse", 32'(quiet), 32'd1);
        send(8'h0F, 8'h01, 1'b0);
        wait_done(lat);
        check("t5_sum_after", 32'(sum), 32'h10);
        check("t5_cout_after", 32'(cout), 32'd0);
        drain();

        // 4: back-to-back with out_ready tied high; accepts WIDTH+2 apart.
        accept_cyc.delete();
        @(posedge clk); #1;
        a = 8'h01; b = 8'h01; cin = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 50 && accept_cyc.size() < 1; i++) begin
            @(posedge clk); #1;
        end
        a = 8'h80; b = 8'h80;
        for (int i = 0; i < 50 && accept_cyc.size() < 2; i++) begin
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("t4_accepts", 32'(accept_cyc.size()), 32'd2);
        if (accept_cyc.size() >= 2)
            check("t4_spacing", 32'(accept_cyc[1] - accept_cyc[0]), 32'(WIDTH + 2));
        drain();
        check("t4_last_sum", 32'(sum), 32'h00);
        check("t4_last_cout", 32'(cout), 32'd1);

`ifdef SERIAL_SUB_EN
        // 6: subtraction mode.
        sub = 1'b1;
        send(8'h10, 8'h01, 1'b0);
        wait_done(lat);
        check("t6a_sum", 32'(sum), 32'h0F);
        check("t6a_cout", 32'(cout), 32'd1);
        send(8'h01, 8'h02, 1'b1);
        wait_done(lat);
        check("t6b_sum", 32'(sum), 32'hFF);
        check("t6b_cout", 32'(cout), 32'd0);
        drain();
        sub = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
